program_loader: RTL and testbench

//  Boot-time loader between uart_rx and the core. Collects bytes from the 9600 bps

---
 rtl/loader_pkg.sv | 10 +
 rtl/word_assembler.sv | 33 +++
 rtl/program_loader.sv | 135 +++++++++++++
 tb/tb_program_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {HDR, DATA, ACK, NAK, DONE, ERR_HALT} loader_state_t;

  localparam logic [7:0]  ACK_BYTE_DEF = 8'hAA;
  localparam logic [7:0]  NAK_BYTE_DEF = 8'hEE;
  localparam int unsigned WORD_BYTES   = 4;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler; word/word_valid are combinational with the 4th byte
// so the consumer can register the result one cycle after the strobe.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_in, shift_q[23:8]};
    end
  end

  assign byte_cnt   = cnt_q;
  assign word_valid = byte_valid && (cnt_q == 2'(WORD_BYTES - 1));
  assign word       = {byte_in, shift_q};

endmodule

// File: rtl/program_loader.sv
// Boot loader: length header plus instruction words from uart_rx into imem, then ACK/NAK
// to the host over uart_tx and release of the core.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 14,
  parameter int unsigned TIMEOUT_CYC = 4_340_000,
  parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_ferr,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   loading,
  output logic                   cpu_start,
  output logic                   load_err
);

  localparam logic [32:0]          CAPACITY = 33'(1) << IMEM_ADDR_W;
  localparam logic [IMEM_ADDR_W:0] CNT_ONE  = (IMEM_ADDR_W + 1)'(1);

  loader_state_t          state;
  logic [IMEM_ADDR_W:0]   word_cnt;
  logic [IMEM_ADDR_W:0]   len;
  logic [31:0]            timer;

  logic        collecting, hdr_idle, frame_err, timed_out, asm_valid, asm_clear;
  logic        word_valid;
  logic [1:0]  byte_cnt;
  logic [31:0] word;

  assign collecting = (state == HDR) || (state == DATA);
  // An idle loader (no header byte yet) neither times out nor reacts to framing errors.
  assign hdr_idle   = (state == HDR) && (byte_cnt == 2'd0);
  assign frame_err  = rx_valid && rx_ferr && collecting && !hdr_idle;
  assign timed_out  = collecting && !hdr_idle && (timer >= TIMEOUT_CYC);
  assign asm_valid  = rx_valid && !rx_ferr && collecting;
  assign asm_clear  = frame_err || timed_out;

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR;
      word_cnt   <= '0;
      len        <= '0;
      timer      <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      tx_data    <= 8'd0;
      tx_start   <= 1'b0;
      loading    <= 1'b0;
      cpu_start  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      tx_start <= 1'b0;

      if (rx_valid || !collecting) begin
        timer <= 32'd0;
      end else if (timer < TIMEOUT_CYC) begin
        timer <= timer + 32'd1;
      end

      unique case (state)
        HDR: begin
          if (asm_valid) loading <= 1'b1;
          if (frame_err || timed_out) begin
            state <= NAK;
          end else if (word_valid) begin
            if ({1'b0, word} > CAPACITY) begin
              state <= NAK;
            end else if (word == 32'd0) begin
              state <= ACK;
            end else begin
              len   <= word[IMEM_ADDR_W:0];
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (frame_err || timed_out) begin
            state <= NAK;
          end else if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[IMEM_ADDR_W-1:0];
            imem_wdata <= word;
            word_cnt   <= word_cnt + CNT_ONE;
          end else if (imem_we && (word_cnt == len)) begin
            state <= ACK;
          end
        end
        ACK: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= ACK_BYTE;
            cpu_start <= 1'b1;
            loading   <= 1'b0;
            state     <= DONE;
          end
        end
        NAK: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= NAK_BYTE;
            load_err <= 1'b1;
            loading  <= 1'b0;
            state    <= ERR_HALT;
          end
        end
        DONE, ERR_HALT: state <= state;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected imem writes and tx bytes are queued by the
// stimulus and popped by an independent monitor.
module tb_program_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ferr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          loading;
  logic          cpu_start;
  logic          load_err;

  program_loader #(
    .IMEM_ADDR_W (AW),
    .TIMEOUT_CYC (TO),
    .ACK_BYTE    (8'hAA),
    .NAK_BYTE    (8'hEE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .loading    (loading),
    .cpu_start  (cpu_start),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int tx_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every imem write and tx request against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        we_cnt++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                   imem_addr, imem_wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("imem_addr", 64'(imem_addr), 64'(e.addr));
          chk("imem_wdata", 64'(imem_wdata), 64'(e.data));
        end
      end
      if (tx_start) begin
        tx_cnt++;
        chk("tx_start_not_busy", 64'(tx_busy), 64'(0));
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: tx_data %0h, expected no tx_start", tx_data);
        end else begin
          logic [7:0] b;
          b = exp_tx.pop_front();
          chk("tx_data", 64'(tx_data), 64'(b));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ferr = 1'b0, input int gap = 20);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    rx_ferr  = ferr;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_data(input logic [AW-1:0] addr, input logic [31:0] w);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_wr.push_back(e);
    send_word(w);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({imem_we, imem_addr, imem_wdata, tx_data, tx_start, loading, cpu_start, load_err}),
        64'(0));
    rst = 1'b0;
    exp_wr.delete();
    exp_tx.delete();
    we_cnt = 0;
    tx_cnt = 0;
  endtask

  task automatic finish_load(input string name, input logic exp_cpu, input logic exp_err,
                             input int exp_we);
    int n;
    n = 0;
    while (!(cpu_start || load_err) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({name, "_completes"}, 64'(n < 3000), 64'(1));
    chk({name, "_cpu_start"}, 64'(cpu_start), 64'(exp_cpu));
    chk({name, "_load_err"}, 64'(load_err), 64'(exp_err));
    chk({name, "_loading"}, 64'(loading), 64'(0));
    chk({name, "_we_count"}, 64'(we_cnt), 64'(exp_we));
    chk({name, "_tx_count"}, 64'(tx_cnt), 64'(1));
    chk({name, "_wr_queue_empty"}, 64'(exp_wr.size()), 64'(0));
    chk({name, "_tx_queue_empty"}, 64'(exp_tx.size()), 64'(0));
  endtask

  initial begin
    do_reset();

    // 1: two words
    exp_tx.push_back(8'hAA);
    send_word(32'd2);
    chk("loading_during_load", 64'(loading), 64'(1));
    send_data(4'd0, 32'h0000_0013);
    send_data(4'd1, 32'hDEAD_BEEF);
    finish_load("t1", 1'b1, 1'b0, 2);

    // 2: empty program
    do_reset();
    exp_tx.push_back(8'hAA);
    send_word(32'd0);
    finish_load("t2", 1'b1, 1'b0, 0);

    // 3: length one past capacity
    do_reset();
    exp_tx.push_back(8'hEE);
    send_word(32'd17);
    finish_load("t3", 1'b0, 1'b1, 0);

    // Exactly full capacity is legal
    do_reset();
    exp_tx.push_back(8'hAA);
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_data(AW'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    finish_load("full", 1'b1, 1'b0, 16);

    // 4: framing error on the second byte of word 1
    do_reset();
    exp_tx.push_back(8'hEE);
    send_word(32'd3);
    send_data(4'd0, 32'hCAFE_F00D);
    send_byte(8'h11);
    send_byte(8'h22, 1'b1);
    finish_load("t4", 1'b0, 1'b1, 1);

    // 5: timeout after the first data byte, stray bytes later ignored
    do_reset();
    exp_tx.push_back(8'hEE);
    send_word(32'd2);
    send_byte(8'h55, 1'b0, TO + 100);
    finish_load("t5", 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(i));
    repeat (20) @(posedge clk);
    #1;
    chk("t5_stray_tx", 64'(tx_cnt), 64'(1));
    chk("t5_stray_we", 64'(we_cnt), 64'(0));

    // Framing error on the very first byte leaves the loader idle
    do_reset();
    send_byte(8'h01, 1'b1);
    chk("ferr_first_loading", 64'(loading), 64'(0));
    chk("ferr_first_load_err", 64'(load_err), 64'(0));
    exp_tx.push_back(8'hAA);
    send_word(32'd1);
    send_data(4'd0, 32'h0123_4567);
    finish_load("ferr_first", 1'b1, 1'b0, 1);

    // 6: tx_busy holds off the ACK
    do_reset();
    exp_tx.push_back(8'hAA);
    send_word(32'd1);
    tx_busy = 1'b1;
    send_data(4'd0, 32'h89AB_CDEF);
    repeat (100) @(posedge clk);
    #1;
    chk("t6_held_tx", 64'(tx_cnt), 64'(0));
    chk("t6_held_cpu_start", 64'(cpu_start), 64'(0));
    tx_busy = 1'b0;
    finish_load("t6", 1'b1, 1'b0, 1);

    // Reset mid-DATA, then a fresh load
    do_reset();
    send_word(32'd3);
    send_data(4'd0, 32'hAAAA_5555);
    send_byte(8'h77);
    send_byte(8'h88);
    chk("mid_we_count", 64'(we_cnt), 64'(1));
    do_reset();
    exp_tx.push_back(8'hAA);
    send_word(32'd1);
    send_data(4'd0, 32'h5A5A_A5A5);
    finish_load("after_reset", 1'b1, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
